// File: rtl/msg_decrypter.sv
// msg_decrypter: recovers an LFSR-scrambled 64-byte message held in mem[64..127].
// The tap polynomial is found by matching the known all-space preamble, then each
// byte is unscrambled and written to mem[0..63].
// Build option: define DEC_STRIP_PREAMBLE_EN to drop the leading spaces and pad the tail.
module msg_decrypter (
   input  logic       clk,
   input  logic       init,
   input  logic       req,
   output logic       ack,
   output logic       err,
   output logic [7:0] mem_raddr,
   input  logic [7:0] mem_rdata,
   output logic       mem_wen,
   output logic [7:0] mem_waddr,
   output logic [7:0] mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEARCH,
      S_DECRYPT,
`ifdef DEC_STRIP_PREAMBLE_EN
      S_PAD,
`endif
      S_DONE
   } state_t;

   function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
      return {s[5:0], ^(s & t)};
   endfunction

   function automatic logic [6:0] tap_of(input logic [3:0] idx);
      case (idx)
         4'd0:    return 7'h60;
         4'd1:    return 7'h48;
         4'd2:    return 7'h78;
         4'd3:    return 7'h72;
         4'd4:    return 7'h6A;
         4'd5:    return 7'h69;
         4'd6:    return 7'h5C;
         4'd7:    return 7'h7E;
         default: return 7'h7B;
      endcase
   endfunction

   state_t     state, state_nx;
   logic [6:0] rd_cnt;     // reads issued in the current phase
   logic [6:0] rx_cnt;     // read bytes consumed in the current phase
   logic       rd_vld;     // mem_raddr carries a live request this cycle
   logic       rx_vld;     // mem_rdata carries a requested byte this cycle
   logic [6:0] ld_buf [10];
   logic [3:0] tap_idx;
   logic [6:0] tap_q;
   logic [6:0] lfsr_q;
   logic [6:0] wr_ptr;
   logic       err_q;
   logic       issue;
   logic       tap_match;
   logic       seed_zero;
   logic [6:0] cand_tap;
   logic [6:0] probe;
   logic [7:0] plain;
   logic       keep;
   logic       dec_wr;
   logic       unused_rdata_msb;

   assign unused_rdata_msb = mem_rdata[7];
   assign cand_tap  = tap_of(tap_idx);
   assign seed_zero = (ld_buf[0] == 7'h00);
   assign issue     = ((state == S_LOAD)    && (rd_cnt < 7'd10)) ||
                      ((state == S_DECRYPT) && (rd_cnt < 7'd64));
   assign plain     = {1'b0, mem_rdata[6:0] ^ lfsr_q} + 8'h20;
   assign dec_wr    = (state == S_DECRYPT) && rx_vld && keep;

`ifdef DEC_STRIP_PREAMBLE_EN
   logic started_q;
   logic pad_wr;
   assign keep   = started_q || (plain != 8'h20);
   assign pad_wr = (state == S_PAD) && !wr_ptr[6];
`else
   assign keep   = 1'b1;
`endif

   // Candidate tap check: step the seed nine times and compare against the preamble buffer
   always_comb begin
      probe     = ld_buf[0];
      tap_match = 1'b1;
      for (int unsigned k = 1; k < 10; k++) begin
         probe = lfsr_step(probe, cand_tap);
         if (probe != ld_buf[k]) tap_match = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (init) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (!req) state_nx = S_LOAD;
         S_LOAD:    if (rx_vld && (rx_cnt == 7'd9)) state_nx = S_SEARCH;
         S_SEARCH: begin
            if (seed_zero)              state_nx = S_DONE;
            else if (tap_match)         state_nx = S_DECRYPT;
            else if (tap_idx == 4'd8)   state_nx = S_DONE;
         end
         S_DECRYPT: begin
            if (rx_vld && (rx_cnt == 7'd63)) begin
`ifdef DEC_STRIP_PREAMBLE_EN
               state_nx = S_PAD;
`else
               state_nx = S_DONE;
`endif
            end
         end
`ifdef DEC_STRIP_PREAMBLE_EN
         S_PAD:     if (wr_ptr >= 7'd63) state_nx = S_DONE;
`endif
         S_DONE:    if (req) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Datapath: read pipeline, preamble buffer, tap search and keystream
   always_ff @(posedge clk) begin
      if (init) begin
         rd_cnt    <= '0;
         rx_cnt    <= '0;
         rd_vld    <= 1'b0;
         rx_vld    <= 1'b0;
         mem_raddr <= '0;
         tap_idx   <= '0;
         tap_q     <= '0;
         lfsr_q    <= '0;
         wr_ptr    <= '0;
         err_q     <= 1'b0;
         for (int unsigned i = 0; i < 10; i++) ld_buf[i] <= '0;
`ifdef DEC_STRIP_PREAMBLE_EN
         started_q <= 1'b0;
`endif
      end else begin
         rd_vld <= issue;
         rx_vld <= rd_vld;
         if (issue) begin
            mem_raddr <= 8'd64 + {1'b0, rd_cnt};
            rd_cnt    <= rd_cnt + 7'd1;
         end
         case (state)
            S_IDLE: begin
               rd_cnt  <= '0;
               rx_cnt  <= '0;
               tap_idx <= '0;
               wr_ptr  <= '0;
               err_q   <= 1'b0;
`ifdef DEC_STRIP_PREAMBLE_EN
               started_q <= 1'b0;
`endif
            end
            S_LOAD: begin
               if (rx_vld) begin
                  ld_buf[rx_cnt[3:0]] <= mem_rdata[6:0];
                  rx_cnt              <= rx_cnt + 7'd1;
               end
            end
            S_SEARCH: begin
               rd_cnt  <= '0;
               rx_cnt  <= '0;
               tap_idx <= tap_idx + 4'd1;
               tap_q   <= cand_tap;
               lfsr_q  <= ld_buf[0];
               if (seed_zero || (!tap_match && (tap_idx == 4'd8))) err_q <= 1'b1;
            end
            S_DECRYPT: begin
               if (rx_vld) begin
                  rx_cnt <= rx_cnt + 7'd1;
                  lfsr_q <= lfsr_step(lfsr_q, tap_q);
                  if (keep) wr_ptr <= wr_ptr + 7'd1;
`ifdef DEC_STRIP_PREAMBLE_EN
                  if (keep) started_q <= 1'b1;
`endif
               end
            end
`ifdef DEC_STRIP_PREAMBLE_EN
            S_PAD: if (pad_wr) wr_ptr <= wr_ptr + 7'd1;
`endif
            default: ;
         endcase
      end
   end

   // Outputs; the write port is combinational so the last byte lands on the edge that leaves the phase
   always_comb begin
      ack       = (state == S_DONE);
      err       = err_q && (state == S_DONE);
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (!init) begin
         if (dec_wr) begin
            mem_wen   = 1'b1;
            mem_waddr = {1'b0, wr_ptr};
            mem_wdata = plain;
         end
`ifdef DEC_STRIP_PREAMBLE_EN
         if (pad_wr) begin
            mem_wen   = 1'b1;
            mem_waddr = {1'b0, wr_ptr};
            mem_wdata = 8'h20;
         end
`endif
      end
   end

endmodule
